// File: rtl/o_serdes_tx_gearbox_pkg.sv
// Shared definitions for the O_SERDES transmit gearbox: FSM state encoding,
// default link-training word and parameter legality helpers.
package o_serdes_tx_gearbox_pkg;

  typedef enum logic [1:0] {
    StWaitLock = 2'd0,
    StTrain    = 2'd1,
    StData     = 2'd2
  } state_e;

  // Alternating 0/1 pattern; only the low WIDTH bits are ever driven.
  localparam logic [9:0] DefaultTrainPattern = 10'b0101010101;

  localparam int unsigned MinWidth = 3;
  localparam int unsigned MaxWidth = 10;
  localparam int unsigned MinRatio = 2;
  localparam int unsigned MaxRatio = 8;

  function automatic bit width_legal(int unsigned w);
    return (w >= MinWidth) && (w <= MaxWidth);
  endfunction

  function automatic bit ratio_legal(int unsigned r);
    return (r >= MinRatio) && (r <= MaxRatio);
  endfunction

endpackage

// File: rtl/o_serdes_tx_gearbox_if.sv
// Wide-word valid/ready stream into the gearbox.
//   S_DATA  : WIDTH*RATIO-bit word, slice k = S_DATA[k*WIDTH +: WIDTH]
//   S_VALID : S_DATA valid (driven by master)
//   S_READY : gearbox accepts S_DATA this cycle (driven by slave)
interface o_serdes_tx_gearbox_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned RATIO = 4
) ();

  logic [WIDTH*RATIO-1:0] S_DATA;
  logic                   S_VALID;
  logic                   S_READY;

  modport master (
    output S_DATA,
    output S_VALID,
    input  S_READY
  );

  modport slave (
    input  S_DATA,
    input  S_VALID,
    output S_READY
  );

endinterface

// File: rtl/o_serdes_tx_gearbox_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset, output resets to 0
//   d_i    : asynchronous input
//   q_o    : synchronized output, two cycles of latency
module o_serdes_tx_gearbox_sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/o_serdes_tx_gearbox.sv
// Transmit gearbox feeding O_SERDES: slices each wide stream word into RATIO
// WIDTH-bit words (LSB slice first), emits a training burst after PLL lock or
// on request, and drives the serializer output enable.
//   CLK_IN     : fabric clock shared with O_SERDES
//   RST        : asynchronous active-low reset
//   s_if       : wide-word valid/ready stream (slave side)
//   PLL_LOCK   : asynchronous PLL lock status
//   TRAIN_REQ  : level request for a training burst
//   D          : word to serializer
//   DATA_VALID : D valid
//   OE_IN      : serializer output enable
//   TRAINING   : training pattern is on D
//   UNDERFLOW  : sticky, stream ran dry mid-traffic; cleared by training
module o_serdes_tx_gearbox
  import o_serdes_tx_gearbox_pkg::*;
#(
  parameter int unsigned WIDTH         = 4,
  parameter int unsigned RATIO         = 4,
  parameter logic [9:0]  TRAIN_PATTERN = DefaultTrainPattern,
  parameter int unsigned TRAIN_WORDS   = 16
) (
  input  logic                  CLK_IN,
  input  logic                  RST,
  o_serdes_tx_gearbox_if.slave  s_if,
  input  logic                  PLL_LOCK,
  input  logic                  TRAIN_REQ,
  output logic [WIDTH-1:0]      D,
  output logic                  DATA_VALID,
  output logic                  OE_IN,
  output logic                  TRAINING,
  output logic                  UNDERFLOW
);

  if (!width_legal(WIDTH)) begin : g_bad_width
    $error("o_serdes_tx_gearbox: WIDTH must be 3..10");
  end
  if (!ratio_legal(RATIO)) begin : g_bad_ratio
    $error("o_serdes_tx_gearbox: RATIO must be 2..8");
  end
  if (TRAIN_WORDS < 1 || TRAIN_WORDS > 255) begin : g_bad_train_words
    $error("o_serdes_tx_gearbox: TRAIN_WORDS must be 1..255");
  end

  localparam int unsigned       SliceW     = $clog2(RATIO);
  localparam logic [SliceW-1:0] LastSlice  = SliceW'(RATIO - 1);
  localparam logic [WIDTH-1:0]  TrainWord  = TRAIN_PATTERN[WIDTH-1:0];
  localparam logic [7:0]        TrainWords = 8'(TRAIN_WORDS);

  state_e                   state_q, state_d;
  logic [WIDTH-1:0]         d_q, d_d;
  logic                     dv_q, dv_d;
  logic                     oe_q, oe_d;
  logic                     training_q, training_d;
  logic                     underflow_q, underflow_d;
  logic                     started_q, started_d;
  logic                     pending_q, pending_d;
  logic                     full_q, full_d;
  logic [WIDTH*RATIO-1:0]   hold_q, hold_d;
  logic [SliceW-1:0]        slice_q, slice_d;
  logic [7:0]               cnt_q, cnt_d;

  logic                     lock_s;
  logic                     idle;
  logic                     ready;
  logic                     accept;
  logic                     go_train;
  logic                     enter_train;
  logic [SliceW-1:0]        slice_nxt;
  logic [WIDTH-1:0]         hold_slices [RATIO];

  o_serdes_tx_gearbox_sync_2ff u_sync_2ff (
    .clk_i  (CLK_IN),
    .rst_ni (RST),
    .d_i    (PLL_LOCK),
    .q_o    (lock_s)
  );

  for (genvar k = 0; k < RATIO; k++) begin : g_slice
    assign hold_slices[k] = hold_q[k*WIDTH +: WIDTH];
  end

  // Idle: nothing held, or the last slice of the held word is on D now.
  assign idle      = !full_q || (slice_q == LastSlice);
  assign ready     = (state_q == StData) && !pending_q && idle;
  // A request arriving with the handshake wins: that word is refused.
  assign accept    = s_if.S_VALID && ready && !TRAIN_REQ;
  assign go_train  = (pending_q || TRAIN_REQ) && idle;
  assign slice_nxt = slice_q + SliceW'(1);

  assign s_if.S_READY = ready;

  always_comb begin
    state_d     = state_q;
    d_d         = d_q;
    dv_d        = dv_q;
    oe_d        = oe_q;
    training_d  = training_q;
    underflow_d = underflow_q;
    started_d   = started_q;
    pending_d   = pending_q;
    full_d      = full_q;
    hold_d      = hold_q;
    slice_d     = slice_q;
    cnt_d       = cnt_q;
    enter_train = 1'b0;

    unique case (state_q)
      StWaitLock: begin
        d_d        = '0;
        dv_d       = 1'b0;
        oe_d       = 1'b0;
        training_d = 1'b0;
        if (lock_s) enter_train = 1'b1;
      end
      StTrain: begin
        // cnt_q counts words already presented on D.
        if (cnt_q == TrainWords) begin
          state_d    = StData;
          dv_d       = 1'b0;
          training_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StData: begin
        if (TRAIN_REQ) pending_d = 1'b1;
        if (accept) begin
          hold_d    = s_if.S_DATA;
          d_d       = s_if.S_DATA[WIDTH-1:0];
          dv_d      = 1'b1;
          full_d    = 1'b1;
          slice_d   = '0;
          started_d = 1'b1;
        end else if (!idle) begin
          slice_d = slice_nxt;
          d_d     = hold_slices[slice_nxt];
          dv_d    = 1'b1;
        end else if (go_train) begin
          enter_train = 1'b1;
        end else begin
          // Stream gap: D keeps its last value.
          dv_d   = 1'b0;
          full_d = 1'b0;
          if (started_q) underflow_d = 1'b1;
        end
      end
      default: state_d = StWaitLock;
    endcase

    if (enter_train) begin
      state_d     = StTrain;
      d_d         = TrainWord;
      dv_d        = 1'b1;
      oe_d        = 1'b1;
      training_d  = 1'b1;
      cnt_d       = 8'd1;
      underflow_d = 1'b0;
      started_d   = 1'b0;
      pending_d   = 1'b0;
      full_d      = 1'b0;
      slice_d     = '0;
    end

    // Loss of lock overrides everything and drops any held word.
    if (!lock_s && (state_q != StWaitLock)) begin
      state_d    = StWaitLock;
      d_d        = '0;
      dv_d       = 1'b0;
      oe_d       = 1'b0;
      training_d = 1'b0;
      started_d  = 1'b0;
      pending_d  = 1'b0;
      full_d     = 1'b0;
      slice_d    = '0;
      cnt_d      = '0;
    end
  end

  always_ff @(posedge CLK_IN or negedge RST) begin
    if (!RST) begin
      state_q     <= StWaitLock;
      d_q         <= '0;
      dv_q        <= 1'b0;
      oe_q        <= 1'b0;
      training_q  <= 1'b0;
      underflow_q <= 1'b0;
      started_q   <= 1'b0;
      pending_q   <= 1'b0;
      full_q      <= 1'b0;
      hold_q      <= '0;
      slice_q     <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      d_q         <= d_d;
      dv_q        <= dv_d;
      oe_q        <= oe_d;
      training_q  <= training_d;
      underflow_q <= underflow_d;
      started_q   <= started_d;
      pending_q   <= pending_d;
      full_q      <= full_d;
      hold_q      <= hold_d;
      slice_q     <= slice_d;
      cnt_q       <= cnt_d;
    end
  end

  assign D          = d_q;
  assign DATA_VALID = dv_q;
  assign OE_IN      = oe_q;
  assign TRAINING   = training_q;
  assign UNDERFLOW  = underflow_q;

endmodule

// File: tb/tb_o_serdes_tx_gearbox.sv
// Directed bench for o_serdes_tx_gearbox (WIDTH=4, RATIO=4, TRAIN_WORDS=16).
// Observed vector: {D[3:0], DATA_VALID, OE_IN, TRAINING, UNDERFLOW, S_READY}.
module tb_o_serdes_tx_gearbox;

  logic       clk;
  logic       rst;
  logic       pll_lock;
  logic       train_req;
  logic [3:0] d;
  logic       dv;
  logic       oe;
  logic       training;
  logic       underflow;
  logic [8:0] obs;

  int checks;
  int failures;

  o_serdes_tx_gearbox_if #(.WIDTH(4), .RATIO(4)) s_if ();

  o_serdes_tx_gearbox #(
    .WIDTH         (4),
    .RATIO         (4),
    .TRAIN_PATTERN (10'b0101010101),
    .TRAIN_WORDS   (16)
  ) dut (
    .CLK_IN     (clk),
    .RST        (rst),
    .s_if       (s_if.slave),
    .PLL_LOCK   (pll_lock),
    .TRAIN_REQ  (train_req),
    .D          (d),
    .DATA_VALID (dv),
    .OE_IN      (oe),
    .TRAINING   (training),
    .UNDERFLOW  (underflow)
  );

  assign obs = {d, dv, oe, training, underflow, s_if.S_READY};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; pll_lock = 1'b0; train_req = 1'b0;
    s_if.S_VALID = 1'b0; s_if.S_DATA = '0;
    #2;
    checks++;
    if (obs !== 9'b0) begin
      failures++; $display("FAIL reset_async: got %b want %b", obs, 9'b0);
    end
    tick(); tick();
    rst = 1'b1;
    tick();
    checks++;
    if (obs !== 9'b0) begin
      failures++; $display("FAIL reset_nolock: got %b want %b", obs, 9'b0);
    end
  endtask

  task automatic test_lock_train();
    pll_lock = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (obs !== 9'b0) begin
        failures++; $display("FAIL lock_sync[%0d]: got %b want %b", i, obs, 9'b0);
      end
    end
    for (int i = 0; i < 16; i++) begin
      tick();
      checks++;
      if (obs !== {4'h5, 5'b11100}) begin
        failures++; $display("FAIL lock_train[%0d]: got %b want %b", i, obs, {4'h5, 5'b11100});
      end
    end
    tick();
    checks++;
    if (obs !== {4'h5, 5'b01001}) begin
      failures++; $display("FAIL lock_to_data: got %b want %b", obs, {4'h5, 5'b01001});
    end
  endtask

  task automatic test_stream();
    logic [3:0] exp_d [8] = '{4'h3, 4'hC, 4'h5, 4'hA, 4'h4, 4'h3, 4'h2, 4'h1};
    logic [8:0] exp_v;
    s_if.S_DATA = 16'hA5C3; s_if.S_VALID = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      exp_v = {exp_d[i], 4'b1100, (i % 4 == 3)};
      checks++;
      if (obs !== exp_v) begin
        failures++; $display("FAIL stream[%0d]: got %b want %b", i, obs, exp_v);
      end
      if (i == 0) s_if.S_DATA = 16'h1234;
      if (i == 7) s_if.S_VALID = 1'b0;
    end
    tick();
    checks++;
    if (obs !== {4'h1, 5'b01011}) begin
      failures++; $display("FAIL stream_gap: got %b want %b", obs, {4'h1, 5'b01011});
    end
  endtask

  task automatic test_gap();
    logic [3:0] exp_d [4] = '{4'h3, 4'hC, 4'h5, 4'hA};
    logic [8:0] exp_v;
    s_if.S_DATA = 16'hA5C3; s_if.S_VALID = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 0) s_if.S_VALID = 1'b0;
      exp_v = {exp_d[i], 4'b1101, (i == 3)};
      checks++;
      if (obs !== exp_v) begin
        failures++; $display("FAIL gap_word[%0d]: got %b want %b", i, obs, exp_v);
      end
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs !== {4'hA, 5'b01011}) begin
        failures++; $display("FAIL gap_hold[%0d]: got %b want %b", i, obs, {4'hA, 5'b01011});
      end
    end
  endtask

  task automatic test_train_req();
    logic [3:0] exp_d [4] = '{4'hF, 4'hE, 4'hE, 4'hB};
    s_if.S_DATA = 16'hBEEF; s_if.S_VALID = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (obs !== {exp_d[i], 5'b11010}) begin
        failures++; $display("FAIL req_slice[%0d]: got %b want %b", i, obs, {exp_d[i], 5'b11010});
      end
      if (i == 0) s_if.S_DATA = 16'h7777;
      if (i == 1) train_req = 1'b1;
      if (i == 2) train_req = 1'b0;
      if (i == 3) s_if.S_VALID = 1'b0;
    end
    for (int i = 0; i < 16; i++) begin
      tick();
      checks++;
      if (obs !== {4'h5, 5'b11100}) begin
        failures++; $display("FAIL req_train[%0d]: got %b want %b", i, obs, {4'h5, 5'b11100});
      end
    end
    tick();
    checks++;
    if (obs !== {4'h5, 5'b01001}) begin
      failures++; $display("FAIL req_to_data: got %b want %b", obs, {4'h5, 5'b01001});
    end
  endtask

  task automatic test_req_last_slice();
    logic [3:0] exp_d [4] = '{4'h1, 4'h2, 4'h3, 4'h4};
    s_if.S_DATA = 16'h4321; s_if.S_VALID = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (obs !== {exp_d[i], 4'b1100, (i == 3)}) begin
        failures++; $display("FAIL last_slice[%0d]: got %b want %b", i, obs,
                             {exp_d[i], 4'b1100, (i == 3)});
      end
      if (i == 0) s_if.S_DATA = 16'h9876;
    end
    train_req = 1'b1;
    tick();
    train_req = 1'b0; s_if.S_VALID = 1'b0;
    checks++;
    if (obs !== {4'h5, 5'b11100}) begin
      failures++; $display("FAIL last_refused: got %b want %b", obs, {4'h5, 5'b11100});
    end
    for (int i = 0; i < 15; i++) begin
      tick();
      checks++;
      if (obs !== {4'h5, 5'b11100}) begin
        failures++; $display("FAIL last_train[%0d]: got %b want %b", i, obs, {4'h5, 5'b11100});
      end
    end
    tick();
    checks++;
    if (obs !== {4'h5, 5'b01001}) begin
      failures++; $display("FAIL last_to_data: got %b want %b", obs, {4'h5, 5'b01001});
    end
  endtask

  task automatic test_lock_drop();
    logic [7:0] part;
    s_if.S_DATA = 16'h5678; s_if.S_VALID = 1'b1;
    tick();
    s_if.S_VALID = 1'b0;
    checks++;
    if (obs !== {4'h8, 5'b11000}) begin
      failures++; $display("FAIL drop_slice0: got %b want %b", obs, {4'h8, 5'b11000});
    end
    tick(); tick();
    checks++;
    if (obs !== {4'h6, 5'b11000}) begin
      failures++; $display("FAIL drop_slice2: got %b want %b", obs, {4'h6, 5'b11000});
    end
    pll_lock = 1'b0;
    tick(); tick(); tick();
    part = {d, dv, oe, training, s_if.S_READY};
    checks++;
    if (part !== 8'h00) begin
      failures++; $display("FAIL drop_outputs: got %b want %b", part, 8'h00);
    end
    pll_lock = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      part = {d, dv, oe, training, s_if.S_READY};
      checks++;
      if (part !== 8'h00) begin
        failures++; $display("FAIL relock_sync[%0d]: got %b want %b", i, part, 8'h00);
      end
    end
    for (int i = 0; i < 16; i++) begin
      tick();
      checks++;
      if (obs !== {4'h5, 5'b11100}) begin
        failures++; $display("FAIL relock_train[%0d]: got %b want %b", i, obs, {4'h5, 5'b11100});
      end
    end
    tick();
    checks++;
    if (obs !== {4'h5, 5'b01001}) begin
      failures++; $display("FAIL relock_to_data: got %b want %b", obs, {4'h5, 5'b01001});
    end
    s_if.S_DATA = 16'hCAFE; s_if.S_VALID = 1'b1;
    tick();
    checks++;
    if (obs !== {4'hE, 5'b11000}) begin
      failures++; $display("FAIL relock_data: got %b want %b", obs, {4'hE, 5'b11000});
    end
  endtask

  task automatic test_reset_mid_word();
    tick();
    checks++;
    if (obs !== {4'hF, 5'b11000}) begin
      failures++; $display("FAIL mid_slice1: got %b want %b", obs, {4'hF, 5'b11000});
    end
    rst = 1'b0; s_if.S_VALID = 1'b0;
    #1;
    checks++;
    if (obs !== 9'b0) begin
      failures++; $display("FAIL mid_reset_async: got %b want %b", obs, 9'b0);
    end
    tick();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (obs !== 9'b0) begin
        failures++; $display("FAIL mid_release[%0d]: got %b want %b", i, obs, 9'b0);
      end
    end
    tick();
    checks++;
    if (obs !== {4'h5, 5'b11100}) begin
      failures++; $display("FAIL mid_retrain: got %b want %b", obs, {4'h5, 5'b11100});
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_lock_train();
    test_stream();
    test_gap();
    test_train_req();
    test_req_last_slice();
    test_lock_drop();
    test_reset_mid_word();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/o_serdes_tx_gearbox.md
Name: o_serdes_tx_gearbox

Overview:
- Upstream feeder for the O_SERDES transmit serializer in the fabric clock domain (CLK_IN).
- Accepts wide parallel words over a valid/ready stream and slices each into RATIO consecutive WIDTH-bit words on D, qualified by DATA_VALID.
- Drives OE_IN for the serializer and inserts a link-training pattern after PLL lock or on request.
- Outputs connect directly to O_SERDES D / DATA_VALID / OE_IN.

Parameters:
- WIDTH, 4, serializer word width; legal 3..10; must match the O_SERDES WIDTH.
- RATIO, 4, slices per input word; legal 2..8.
- TRAIN_PATTERN, 10'b0101010101, training word; only bits [WIDTH-1:0] are used.
- TRAIN_WORDS, 16, number of training words emitted per training burst; legal 1..255.

Ports:
- CLK_IN  input  1  fabric clock, shared with O_SERDES CLK_IN.
- RST  input  1  asynchronous, active-low reset.
- S_DATA  input  WIDTH*RATIO  input word; slice k = S_DATA[k*WIDTH +: WIDTH].
- S_VALID  input  1  S_DATA valid.
- S_READY  output  1  gearbox accepts S_DATA this cycle.
- PLL_LOCK  input  1  asynchronous PLL lock status.
- TRAIN_REQ  input  1  level request for a training burst.
- D  output  WIDTH  word to serializer.
- DATA_VALID  output  1  D valid.
- OE_IN  output  1  output enable to serializer.
- TRAINING  output  1  high while the training pattern is being emitted.
- UNDERFLOW  output  1  sticky flag: stream gap occurred mid-traffic.

Behaviour:
- Reset: asynchronous on RST=0, released synchronously. While in reset: state=WAIT_LOCK, D=0, DATA_VALID=0, OE_IN=0, S_READY=0, TRAINING=0, UNDERFLOW=0, holding register empty, slice index=0, training count=0.
- All outputs are registered except S_READY.
- S_READY = (state==DATA) && !train_pending && (empty || slice_idx==RATIO-1). It is derived from registers only and never depends on S_VALID.
- PLL_LOCK goes through a 2-flop synchronizer; lock_s below is the synchronized value.
- State WAIT_LOCK:
  - D=0, DATA_VALID=0, OE_IN=0.
  - When lock_s=1, move to TRAIN on the next cycle.
- State TRAIN:
  - Each cycle: D=TRAIN_PATTERN[WIDTH-1:0], DATA_VALID=1, OE_IN=1, TRAINING=1.
  - Emits exactly TRAIN_WORDS words, then moves to DATA.
  - Entering TRAIN clears UNDERFLOW and the started flag.
  - TRAIN_REQ is ignored while in TRAIN.
- State DATA:
  - OE_IN=1 throughout.
  - Handshake: a word is accepted when S_VALID && S_READY in cycle t. Slice 0 appears on D with DATA_VALID=1 in cycle t+1, then slices 1..RATIO-1 in cycles t+2..t+RATIO, LSB slice first.
  - Accepting on the last slice gives gap-free streaming at one input word per RATIO cycles.
  - Gap: holding register is empty (or the last slice has been sent) and no word is accepted → DATA_VALID=0 and D holds its last value.
  - UNDERFLOW is set if the gap occurs after at least one word has been accepted since entering DATA.
- TRAIN_REQ while in DATA:
  - Set train_pending, which deasserts S_READY.
  - The current word's remaining slices complete.
  - Then move to TRAIN; if the holding register is empty, move to TRAIN next cycle.
  - TRAIN_REQ together with S_VALID on the last slice: the word is not accepted.
- lock_s falls in any state:
  - Move to WAIT_LOCK next cycle.
  - Any held word is discarded; slice index, train_pending and training count are cleared.
  - DATA_VALID=0 and OE_IN=0 from that next cycle.
- Reset mid-word: the partial word is lost; no partial slices are emitted after reset release.
- The training count and slice index are free of wrap; both reload on entry to their state.

Decomposition:
- Shared package/include: state encodings (WAIT_LOCK=2'd0, TRAIN=2'd1, DATA=2'd2), the WIDTH/RATIO legality checks, and the default TRAIN_PATTERN.
- One sub-module: sync_2ff, a 2-flop synchronizer with async active-low reset and reset value 0, used for PLL_LOCK.

Test Plan:
- Reset then PLL_LOCK=1 (WIDTH=4, TRAIN_WORDS=16) → after 2-cycle sync + 1 cycle: 16 cycles D=4'b0101, DATA_VALID=1, OE_IN=1, TRAINING=1; then S_READY=1.
- Stream S_DATA=16'hA5C3 then 16'h1234 back-to-back → D = 3,C,5,A,4,3,2,1 on 8 consecutive cycles, DATA_VALID=1 throughout, UNDERFLOW=0.
- After one word, hold S_VALID=0 for 3 cycles → DATA_VALID=0 for those cycles, D holds 4'hA, UNDERFLOW=1 until the next training burst.
- TRAIN_REQ pulse during slice 1 of 16'hBEEF → slices E,E,B complete; S_READY stays 0; 16 training words follow; UNDERFLOW cleared.
- PLL_LOCK drops during slice 2 → within 3 cycles DATA_VALID=0, OE_IN=0, S_READY=0; on relock, full training burst precedes data.
- Assert RST=0 mid-word → all outputs 0 immediately; after release, no stale slices appear on D.
